misc_commit: RTL and testbench

MISC_COMMIT -- requirements
Module: MiscCommit

---
 rtl/misc_commit.sv | 270 +++++++++++++++++++++++++++
 tb/tb_misc_commit.sv | 514 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/misc_commit.sv
// misc_commit: commit stage for misc-pipe ops.
// Holds one packet, writes it back to the ROB, waits until that entry is the
// ROB retire head, then performs its side effects (CSR write, TLB invalidate,
// frontend redirect) before pulsing retire and returning to idle.
// Build option: define MISC_COMMIT_PERF_EN to build the redirect / stall
// performance counters; without it both counter outputs are tied to zero.
`timescale 1ns/1ps

package misc_commit_pkg;

    localparam int MISC_ROB_IDX_W = 6;
    localparam int PDEST_W        = 6;
    localparam int PROC_VALEN     = 32;
    localparam int CSR_ADDR_W     = 14;
    localparam int ASID_W         = 10;

    typedef enum logic [1:0] {
        PRIV_NONE   = 2'd0,
        PRIV_TLBINV = 2'd1,
        PRIV_ERTN   = 2'd2,
        PRIV_IDLE   = 2'd3
    } priv_op_e;

    typedef struct packed {
        logic                      valid;
        logic [MISC_ROB_IDX_W-1:0] rob_idx;
        logic                      we;
        logic [PDEST_W-1:0]        pdest;
        logic [31:0]               wdata;
    } MiscCmtBaseSt;

    typedef struct packed {
        MiscCmtBaseSt          base;
        logic                  csr_we;
        logic [CSR_ADDR_W-1:0] csr_waddr;
        logic [31:0]           csr_wdata;
        priv_op_e              priv_op;
        logic [ASID_W-1:0]     invtlb_asid;
        logic [PROC_VALEN-1:0] invtlb_vaddr;
        logic                  br_redirect;
        logic [PROC_VALEN-1:0] br_target;
    } MiscCmtSt;

endpackage

module misc_commit #(
    parameter int ROB_IDX_W = misc_commit_pkg::MISC_ROB_IDX_W
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush_i,
    input  misc_commit_pkg::MiscCmtSt              cmt_i,
    output logic                                   cmt_ready_o,
    output logic                                   wb_valid_o,
    output logic                                   wb_we_o,
    output logic [misc_commit_pkg::PDEST_W-1:0]    wb_pdest_o,
    output logic [31:0]                            wb_wdata_o,
    output logic [ROB_IDX_W-1:0]                   wb_rob_idx_o,
    input  logic                                   rob_head_valid_i,
    input  logic [ROB_IDX_W-1:0]                   rob_head_idx_i,
    output logic                                   csr_we_o,
    output logic [misc_commit_pkg::CSR_ADDR_W-1:0] csr_waddr_o,
    output logic [31:0]                            csr_wdata_o,
    output logic                                   invtlb_valid_o,
    output logic [misc_commit_pkg::ASID_W-1:0]     invtlb_asid_o,
    output logic [misc_commit_pkg::PROC_VALEN-1:0] invtlb_vaddr_o,
    input  logic                                   invtlb_ready_i,
    output logic                                   redirect_o,
    output logic [misc_commit_pkg::PROC_VALEN-1:0] redirect_pc_o,
    output logic                                   retire_o,
    output logic [31:0]                            perf_redirect_cnt_o,
    output logic [31:0]                            perf_stall_cnt_o
);

    import misc_commit_pkg::*;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WB        = 3'd1,
        WAIT_HEAD = 3'd2,
        SIDE      = 3'd3,
        DONE      = 3'd4
    } state_e;

    state_e state_q;
    state_e state_d;

    // Held copy of the accepted packet, split into the fields actually used.
    logic [ROB_IDX_W-1:0]  rob_idx_q;
    logic                  we_q;
    logic [PDEST_W-1:0]    pdest_q;
    logic [31:0]           wdata_q;
    logic                  csr_we_q;
    logic [CSR_ADDR_W-1:0] csr_waddr_q;
    logic [31:0]           csr_wdata_q;
    logic                  tlbinv_q;
    logic [ASID_W-1:0]     asid_q;
    logic [PROC_VALEN-1:0] vaddr_q;
    logic                  br_redirect_q;
    logic [PROC_VALEN-1:0] br_target_q;

    // High only in the first SIDE cycle, so CSR and redirect fire exactly once
    // even when the TLB handshake keeps us in SIDE longer.
    logic side_first_q;

    logic capture;
    logic head_match;
    logic needs_side;
    logic side_complete;

    assign capture       = cmt_i.base.valid & cmt_ready_o;
    assign head_match    = rob_head_valid_i & (rob_head_idx_i == rob_idx_q);
    assign needs_side    = csr_we_q | tlbinv_q | br_redirect_q;
    assign side_complete = ~tlbinv_q | invtlb_ready_i;

    // State register; reset and flush both land in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (capture) state_d = WB;
                WB:        state_d = WAIT_HEAD;
                WAIT_HEAD: if (head_match) state_d = needs_side ? SIDE : DONE;
                SIDE:      if (side_complete) state_d = DONE;
                DONE:      state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Packet hold register: loaded on accept, cleared when flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rob_idx_q     <= '0;
            we_q          <= 1'b0;
            pdest_q       <= '0;
            wdata_q       <= '0;
            csr_we_q      <= 1'b0;
            csr_waddr_q   <= '0;
            csr_wdata_q   <= '0;
            tlbinv_q      <= 1'b0;
            asid_q        <= '0;
            vaddr_q       <= '0;
            br_redirect_q <= 1'b0;
            br_target_q   <= '0;
        end else if (flush_i) begin
            rob_idx_q     <= '0;
            we_q          <= 1'b0;
            pdest_q       <= '0;
            wdata_q       <= '0;
            csr_we_q      <= 1'b0;
            csr_waddr_q   <= '0;
            csr_wdata_q   <= '0;
            tlbinv_q      <= 1'b0;
            asid_q        <= '0;
            vaddr_q       <= '0;
            br_redirect_q <= 1'b0;
            br_target_q   <= '0;
        end else if (capture) begin
            rob_idx_q     <= ROB_IDX_W'(cmt_i.base.rob_idx);
            we_q          <= cmt_i.base.we;
            pdest_q       <= cmt_i.base.pdest;
            wdata_q       <= cmt_i.base.wdata;
            csr_we_q      <= cmt_i.csr_we;
            csr_waddr_q   <= cmt_i.csr_waddr;
            csr_wdata_q   <= cmt_i.csr_wdata;
            tlbinv_q      <= (cmt_i.priv_op == PRIV_TLBINV);
            asid_q        <= cmt_i.invtlb_asid;
            vaddr_q       <= cmt_i.invtlb_vaddr;
            br_redirect_q <= cmt_i.br_redirect;
            br_target_q   <= cmt_i.br_target;
        end
    end

    // Marks the first SIDE cycle (entered only from WAIT_HEAD).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            side_first_q <= 1'b0;
        end else begin
            side_first_q <= (state_q == WAIT_HEAD) && (state_d == SIDE);
        end
    end

    // Outputs decoded from the current state; data buses are zero when idle.
    always_comb begin
        cmt_ready_o    = (state_q == IDLE) & ~flush_i;
        wb_valid_o     = 1'b0;
        wb_we_o        = 1'b0;
        wb_pdest_o     = '0;
        wb_wdata_o     = '0;
        wb_rob_idx_o   = '0;
        csr_we_o       = 1'b0;
        csr_waddr_o    = '0;
        csr_wdata_o    = '0;
        invtlb_valid_o = 1'b0;
        invtlb_asid_o  = '0;
        invtlb_vaddr_o = '0;
        redirect_o     = 1'b0;
        redirect_pc_o  = '0;
        retire_o       = 1'b0;
        case (state_q)
            WB: begin
                wb_valid_o   = 1'b1;
                wb_we_o      = we_q;
                wb_pdest_o   = pdest_q;
                wb_wdata_o   = wdata_q;
                wb_rob_idx_o = rob_idx_q;
            end
            SIDE: begin
                if (side_first_q && csr_we_q) begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = csr_waddr_q;
                    csr_wdata_o = csr_wdata_q;
                end
                if (tlbinv_q) begin
                    invtlb_valid_o = 1'b1;
                    invtlb_asid_o  = asid_q;
                    invtlb_vaddr_o = vaddr_q;
                end
                if (side_first_q && br_redirect_q) begin
                    redirect_o    = 1'b1;
                    redirect_pc_o = br_target_q;
                end
            end
            DONE: begin
                retire_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef MISC_COMMIT_PERF_EN
    logic [31:0] redirect_cnt_q;
    logic [31:0] stall_cnt_q;

    // Free-running wrap-around counters of redirects and head-wait stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if (redirect_o) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
            if ((state_q == WAIT_HEAD) && !head_match) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_redirect_cnt_o = redirect_cnt_q;
    assign perf_stall_cnt_o    = stall_cnt_q;
`else
    assign perf_redirect_cnt_o = 32'd0;
    assign perf_stall_cnt_o    = 32'd0;
`endif

endmodule

// File: tb/tb_misc_commit.sv
// tb_misc_commit: randomized and directed bench for misc_commit.
// Expected timing for each packet is computed from the commit rules:
// writeback one cycle after accept, head wait, side effects, retire.
`timescale 1ns/1ps

module tb_misc_commit;

    import misc_commit_pkg::*;

    localparam int RW = 6;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  flush_i = 1'b0;
    MiscCmtSt              cmt_i = '0;
    logic                  cmt_ready_o;
    logic                  wb_valid_o;
    logic                  wb_we_o;
    logic [PDEST_W-1:0]    wb_pdest_o;
    logic [31:0]           wb_wdata_o;
    logic [RW-1:0]         wb_rob_idx_o;
    logic                  rob_head_valid_i = 1'b0;
    logic [RW-1:0]         rob_head_idx_i = '0;
    logic                  csr_we_o;
    logic [CSR_ADDR_W-1:0] csr_waddr_o;
    logic [31:0]           csr_wdata_o;
    logic                  invtlb_valid_o;
    logic [ASID_W-1:0]     invtlb_asid_o;
    logic [PROC_VALEN-1:0] invtlb_vaddr_o;
    logic                  invtlb_ready_i = 1'b0;
    logic                  redirect_o;
    logic [PROC_VALEN-1:0] redirect_pc_o;
    logic                  retire_o;
    logic [31:0]           perf_redirect_cnt_o;
    logic [31:0]           perf_stall_cnt_o;

    int checks = 0;
    int failures = 0;
    int exp_stall = 0;
    int exp_redirect = 0;

    misc_commit #(.ROB_IDX_W(RW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush_i             (flush_i),
        .cmt_i               (cmt_i),
        .cmt_ready_o         (cmt_ready_o),
        .wb_valid_o          (wb_valid_o),
        .wb_we_o             (wb_we_o),
        .wb_pdest_o          (wb_pdest_o),
        .wb_wdata_o          (wb_wdata_o),
        .wb_rob_idx_o        (wb_rob_idx_o),
        .rob_head_valid_i    (rob_head_valid_i),
        .rob_head_idx_i      (rob_head_idx_i),
        .csr_we_o            (csr_we_o),
        .csr_waddr_o         (csr_waddr_o),
        .csr_wdata_o         (csr_wdata_o),
        .invtlb_valid_o      (invtlb_valid_o),
        .invtlb_asid_o       (invtlb_asid_o),
        .invtlb_vaddr_o      (invtlb_vaddr_o),
        .invtlb_ready_i      (invtlb_ready_i),
        .redirect_o          (redirect_o),
        .redirect_pc_o       (redirect_pc_o),
        .retire_o            (retire_o),
        .perf_redirect_cnt_o (perf_redirect_cnt_o),
        .perf_stall_cnt_o    (perf_stall_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] exp_cnt(input int v);
`ifdef MISC_COMMIT_PERF_EN
        return 32'(v);
`else
        return 32'(v) & 32'h0;
`endif
    endfunction

    function automatic MiscCmtSt rand_pkt();
        MiscCmtSt p;
        p = '0;
        p.base.rob_idx    = 6'($urandom);
        p.base.we         = 1'($urandom);
        p.base.pdest      = 6'($urandom);
        p.base.wdata      = $urandom;
        p.csr_we          = 1'($urandom);
        p.csr_waddr       = 14'($urandom);
        p.csr_wdata       = $urandom;
        p.priv_op         = priv_op_e'($urandom_range(0, 3));
        p.invtlb_asid     = 10'($urandom);
        p.invtlb_vaddr    = $urandom;
        p.br_redirect     = 1'($urandom);
        p.br_target       = $urandom;
        return p;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        flush_i = 1'b0;
        cmt_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_stall = 0;
        exp_redirect = 0;
    endtask

    // Drives one packet from accept through retire and checks every cycle.
    // head_delay = unmatched WAIT_HEAD cycles, rdy_delay = invtlb low cycles.
    task automatic run_packet(input MiscCmtSt p, input int head_delay, input int rdy_delay,
                              input bit chain, input MiscCmtSt nxt);
        bit is_tlb;
        bit has_side;
        int side_start;
        int done_t;
        logic [RW-1:0] other;
        bit e_wb, e_csr, e_red, e_tlb, e_ret;
        is_tlb     = (p.priv_op == PRIV_TLBINV);
        has_side   = p.csr_we || is_tlb || p.br_redirect;
        side_start = 3 + head_delay;
        done_t     = has_side ? side_start + (is_tlb ? rdy_delay + 1 : 1) : 3 + head_delay;

        cmt_i = p;
        cmt_i.base.valid = 1'b1;
        flush_i = 1'b0;
        rob_head_valid_i = 1'($urandom);
        rob_head_idx_i = 6'($urandom);
        invtlb_ready_i = 1'($urandom);
        @(negedge clk);
        checks++;
        if (cmt_ready_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL accept_ready got=%b exp=1", cmt_ready_o);
        end
        @(posedge clk);
        #1;
        cmt_i.base.valid = 1'b0;

        for (int t = 1; t <= done_t; t++) begin
            if (t >= 2 + head_delay) begin
                rob_head_valid_i = 1'b1;
                rob_head_idx_i = p.base.rob_idx;
            end else begin
                other = p.base.rob_idx ^ 6'($urandom_range(1, 63));
                rob_head_valid_i = 1'($urandom);
                rob_head_idx_i = rob_head_valid_i ? other : 6'($urandom);
            end
            if (t < side_start) invtlb_ready_i = 1'($urandom);
            else invtlb_ready_i = (t >= side_start + rdy_delay);
            if (chain && t == done_t) begin
                cmt_i = nxt;
                cmt_i.base.valid = 1'b1;
            end
            @(negedge clk);
            e_wb  = (t == 1);
            e_csr = p.csr_we && (t == side_start);
            e_red = p.br_redirect && (t == side_start);
            e_tlb = is_tlb && (t >= side_start) && (t <= side_start + rdy_delay);
            e_ret = (t == done_t);
            checks += 6;
            if (wb_valid_o !== e_wb) begin
                failures++;
                $display("[TB] FAIL wb_valid t=%0d got=%b exp=%b", t, wb_valid_o, e_wb);
            end
            if (csr_we_o !== e_csr) begin
                failures++;
                $display("[TB] FAIL csr_we t=%0d got=%b exp=%b", t, csr_we_o, e_csr);
            end
            if (redirect_o !== e_red) begin
                failures++;
                $display("[TB] FAIL redirect t=%0d got=%b exp=%b", t, redirect_o, e_red);
            end
            if (invtlb_valid_o !== e_tlb) begin
                failures++;
                $display("[TB] FAIL invtlb_valid t=%0d got=%b exp=%b", t, invtlb_valid_o, e_tlb);
            end
            if (retire_o !== e_ret) begin
                failures++;
                $display("[TB] FAIL retire t=%0d got=%b exp=%b", t, retire_o, e_ret);
            end
            if (cmt_ready_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL busy_ready t=%0d got=%b exp=0", t, cmt_ready_o);
            end
            if (e_wb) begin
                checks++;
                if ({wb_we_o, wb_pdest_o, wb_wdata_o, wb_rob_idx_o} !==
                    {p.base.we, p.base.pdest, p.base.wdata, p.base.rob_idx}) begin
                    failures++;
                    $display("[TB] FAIL wb_data got=%b/%h/%h/%h exp=%b/%h/%h/%h",
                             wb_we_o, wb_pdest_o, wb_wdata_o, wb_rob_idx_o,
                             p.base.we, p.base.pdest, p.base.wdata, p.base.rob_idx);
                end
            end
            if (e_csr) begin
                checks++;
                if ({csr_waddr_o, csr_wdata_o} !== {p.csr_waddr, p.csr_wdata}) begin
                    failures++;
                    $display("[TB] FAIL csr_data got=%h/%h exp=%h/%h",
                             csr_waddr_o, csr_wdata_o, p.csr_waddr, p.csr_wdata);
                end
            end
            if (e_red) begin
                checks++;
                if (redirect_pc_o !== p.br_target) begin
                    failures++;
                    $display("[TB] FAIL redirect_pc got=%h exp=%h", redirect_pc_o, p.br_target);
                end
            end
            if (e_tlb) begin
                checks++;
                if ({invtlb_asid_o, invtlb_vaddr_o} !== {p.invtlb_asid, p.invtlb_vaddr}) begin
                    failures++;
                    $display("[TB] FAIL invtlb_data t=%0d got=%h/%h exp=%h/%h", t,
                             invtlb_asid_o, invtlb_vaddr_o, p.invtlb_asid, p.invtlb_vaddr);
                end
            end
            @(posedge clk);
            #1;
        end

        exp_stall += head_delay;
        if (p.br_redirect) exp_redirect++;

        if (!chain) begin
            cmt_i.base.valid = 1'b0;
            rob_head_valid_i = 1'b0;
            invtlb_ready_i = 1'b0;
            @(negedge clk);
            checks += 4;
            if (cmt_ready_o !== 1'b1) begin
                failures++;
                $display("[TB] FAIL idle_ready got=%b exp=1", cmt_ready_o);
            end
            if ({wb_valid_o, retire_o, csr_we_o, redirect_o, invtlb_valid_o} !== 5'b0) begin
                failures++;
                $display("[TB] FAIL idle_pulses got=%b exp=00000",
                         {wb_valid_o, retire_o, csr_we_o, redirect_o, invtlb_valid_o});
            end
            if (perf_stall_cnt_o !== exp_cnt(exp_stall)) begin
                failures++;
                $display("[TB] FAIL perf_stall got=%0d exp=%0d", perf_stall_cnt_o, exp_cnt(exp_stall));
            end
            if (perf_redirect_cnt_o !== exp_cnt(exp_redirect)) begin
                failures++;
                $display("[TB] FAIL perf_redirect got=%0d exp=%0d",
                         perf_redirect_cnt_o, exp_cnt(exp_redirect));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #2;
        checks += 3;
        if (cmt_ready_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready got=%b exp=1", cmt_ready_o);
        end
        if ({wb_valid_o, retire_o, csr_we_o, redirect_o, invtlb_valid_o, wb_wdata_o} !== 37'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h exp=0",
                     {wb_valid_o, retire_o, csr_we_o, redirect_o, invtlb_valid_o, wb_wdata_o});
        end
        if ({perf_stall_cnt_o, perf_redirect_cnt_o} !== 64'b0) begin
            failures++;
            $display("[TB] FAIL reset_perf got=%h exp=0", {perf_stall_cnt_o, perf_redirect_cnt_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_branch_link();
        MiscCmtSt p;
        p = '0;
        p.base.rob_idx = 6'd5;
        p.base.we = 1'b1;
        p.base.pdest = 6'd1;
        p.base.wdata = 32'h1C00_0044;
        p.priv_op = PRIV_NONE;
        run_packet(p, 0, 0, 1'b0, p);
    endtask

    task automatic test_csr_stall();
        MiscCmtSt p;
        do_reset();
        p = '0;
        p.base.rob_idx = 6'd17;
        p.base.we = 1'b1;
        p.base.pdest = 6'd9;
        p.base.wdata = 32'hDEAD_0001;
        p.csr_we = 1'b1;
        p.csr_waddr = 14'h00C;
        p.csr_wdata = 32'h0000_1234;
        run_packet(p, 4, 0, 1'b0, p);
        checks++;
        if (perf_stall_cnt_o !== exp_cnt(4)) begin
            failures++;
            $display("[TB] FAIL csr_stall_cnt got=%0d exp=%0d", perf_stall_cnt_o, exp_cnt(4));
        end
    endtask

    task automatic test_invtlb();
        MiscCmtSt p;
        p = '0;
        p.base.rob_idx = 6'd40;
        p.priv_op = PRIV_TLBINV;
        p.invtlb_asid = 10'h003;
        p.invtlb_vaddr = 32'h0040_2000;
        run_packet(p, 1, 3, 1'b0, p);
    endtask

    task automatic test_redirect();
        MiscCmtSt p;
        do_reset();
        p = '0;
        p.base.rob_idx = 6'd63;
        p.br_redirect = 1'b1;
        p.br_target = 32'h1C00_0100;
        run_packet(p, 2, 0, 1'b0, p);
        checks++;
        if (perf_redirect_cnt_o !== exp_cnt(1)) begin
            failures++;
            $display("[TB] FAIL redirect_cnt got=%0d exp=%0d", perf_redirect_cnt_o, exp_cnt(1));
        end
    endtask

    task automatic test_flush();
        MiscCmtSt p;
        p = '0;
        p.base.rob_idx = 6'd9;
        p.csr_we = 1'b1;
        p.br_redirect = 1'b1;
        p.br_target = 32'h1C00_0200;
        cmt_i = p;
        cmt_i.base.valid = 1'b1;
        rob_head_valid_i = 1'b0;
        @(posedge clk);
        #1;
        cmt_i.base.valid = 1'b0;
        // WB then one unmatched WAIT_HEAD cycle, flush on the second
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        checks++;
        if (cmt_ready_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_ready_same got=%b exp=0", cmt_ready_o);
        end
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        rob_head_valid_i = 1'b1;
        rob_head_idx_i = 6'd9;
        exp_stall += 2;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            checks += 2;
            if (cmt_ready_o !== 1'b1) begin
                failures++;
                $display("[TB] FAIL flush_idle_ready t=%0d got=%b exp=1", t, cmt_ready_o);
            end
            if ({wb_valid_o, csr_we_o, redirect_o, retire_o, invtlb_valid_o} !== 5'b0) begin
                failures++;
                $display("[TB] FAIL flush_pulses t=%0d got=%b exp=00000", t,
                         {wb_valid_o, csr_we_o, redirect_o, retire_o, invtlb_valid_o});
            end
            @(posedge clk);
            #1;
        end
        rob_head_valid_i = 1'b0;
        checks++;
        if (perf_stall_cnt_o !== exp_cnt(exp_stall)) begin
            failures++;
            $display("[TB] FAIL flush_stall_cnt got=%0d exp=%0d", perf_stall_cnt_o, exp_cnt(exp_stall));
        end
    endtask

    task automatic test_flush_capture();
        cmt_i = rand_pkt();
        cmt_i.base.valid = 1'b1;
        flush_i = 1'b1;
        @(negedge clk);
        checks++;
        if (cmt_ready_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_cap_ready got=%b exp=0", cmt_ready_o);
        end
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        cmt_i.base.valid = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if ({wb_valid_o, cmt_ready_o} !== 2'b01) begin
                failures++;
                $display("[TB] FAIL flush_cap_drop t=%0d got=%b exp=01", t, {wb_valid_o, cmt_ready_o});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        MiscCmtSt cur;
        MiscCmtSt nxt;
        cur = rand_pkt();
        for (int i = 0; i < 4; i++) begin
            nxt = rand_pkt();
            run_packet(cur, i, i, (i != 3), nxt);
            cur = nxt;
        end
    endtask

    task automatic test_random();
        MiscCmtSt cur;
        MiscCmtSt nxt;
        bit chain;
        cur = rand_pkt();
        for (int i = 0; i < 30; i++) begin
            nxt = rand_pkt();
            chain = (i != 29) && ($urandom_range(0, 1) == 1);
            run_packet(cur, $urandom_range(0, 5), $urandom_range(0, 4), chain, nxt);
            cur = nxt;
        end
    endtask

    task automatic test_reset_mid_invtlb();
        MiscCmtSt p;
        p = '0;
        p.base.rob_idx = 6'd12;
        p.priv_op = PRIV_TLBINV;
        p.invtlb_asid = 10'h155;
        p.invtlb_vaddr = 32'h0123_4000;
        cmt_i = p;
        cmt_i.base.valid = 1'b1;
        rob_head_valid_i = 1'b1;
        rob_head_idx_i = 6'd12;
        invtlb_ready_i = 1'b0;
        @(posedge clk);
        #1;
        cmt_i.base.valid = 1'b0;
        // WB, head match, then two SIDE cycles with ready held low
        for (int t = 0; t < 4; t++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (invtlb_valid_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_mid_pre got=%b exp=1", invtlb_valid_o);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({invtlb_valid_o, invtlb_asid_o, invtlb_vaddr_o, wb_valid_o, retire_o, csr_we_o, redirect_o} !== 47'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid_outputs got=%h exp=0",
                     {invtlb_valid_o, invtlb_asid_o, invtlb_vaddr_o, wb_valid_o, retire_o, csr_we_o, redirect_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        rob_head_valid_i = 1'b0;
        #1;
        exp_stall = 0;
        exp_redirect = 0;
        checks += 2;
        if (cmt_ready_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_mid_ready got=%b exp=1", cmt_ready_o);
        end
        if ({perf_stall_cnt_o, perf_redirect_cnt_o} !== 64'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid_perf got=%h exp=0", {perf_stall_cnt_o, perf_redirect_cnt_o});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_branch_link();
        test_csr_stall();
        test_invtlb();
        test_redirect();
        test_flush();
        test_flush_capture();
        test_back_to_back();
        test_random();
        test_reset_mid_invtlb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
